dev_port_arbiter: RTL and testbench
===================================

// Module: dev_port_arbiter
// PURPOSE
//  Shares one Ibex-style device (target) port between NUM_REQ requesters, e.g. core data port plus debug/DMA.
//  Round-robin arbitration; at most one transaction outstanding; responses routed back to the owning requester.
//  Sits upstream of the device-to-AXI-Lite bridge and drives its data_* inputs directly.
//  A watchdog converts a lost response into an error response, then drains the late reply.
// PARAMETERS
//  NUM_REQ  2     number of requesters (>=2); IW = $clog2(NUM_REQ)
//  TIMEOUT  1024  max cycles in S_WAIT before error response; 0 disables watchdog
// PORTS
//  clk            in   1          single clock, all logic posedge
//  rst            in   1          asynchronous reset, active-high
//  s_req_i        in   NUM_REQ    per-requester request
//  s_addr_i       in   NUM_REQ*32 word address, requester k at [32k+:32]
//  s_we_i         in   NUM_REQ    1=write
//  s_be_i         in   NUM_REQ*4  byte enables
//  s_wdata_i      in   NUM_REQ*32 write data
//  s_gnt_o        out  NUM_REQ    one-hot grant (same cycle as accepted req)
//  s_rvalid_o     out  NUM_REQ    one-hot response pulse to owner
//  s_err_o        out  NUM_REQ    error, valid with s_rvalid_o
//  s_rdata_o      out  NUM_REQ*32 read data, valid with s_rvalid_o
//  m_req_o        out  1          to bridge data_req_i
//  m_addr_o       out  32         to bridge data_addr_i
//  m_we_o         out  1          to bridge data_we_i
//  m_be_o         out  4          to bridge data_be_i
//  m_wdata_o      out  32         to bridge data_wdata_i
//  m_gnt_i        in   1          from bridge data_gnt_o
//  m_rvalid_i     in   1          from bridge data_rvalid_o
//  m_err_i        in   1          from bridge data_err_o
//  m_rdata_i      in   32         from bridge data_rdata_o
//  timeout_o      out  1          1-cycle pulse when watchdog fires
// BEHAVIOUR
//  Reset: state=S_IDLE, rr_ptr=0, owner=0, wd_cnt=0; all outputs 0.
//  FSM: S_IDLE, S_WAIT, S_DRAIN.
//  S_IDLE:
//   - winner = first k with s_req_i[k]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - m_req_o = |s_req_i; m_addr/we/be/wdata_o = winner fields (all 0 when no request).
//   - s_gnt_o[winner] = m_gnt_i; every other gnt bit is 0.
//   - On m_gnt_i & m_req_o: owner<=winner, rr_ptr<=(winner+1) mod NUM_REQ, wd_cnt<=0, go S_WAIT.
//   - m_rvalid_i in S_IDLE is ignored (stray or pre-reset response).
//  S_WAIT:
//   - m_req_o=0 and data outputs 0; no grants issued.
//   - On m_rvalid_i: s_rvalid_o[owner]=1, s_err_o[owner]=m_err_i, s_rdata_o[owner]=m_rdata_i combinationally (0 added latency); go S_IDLE.
//   - Else wd_cnt++. If TIMEOUT!=0 and wd_cnt==TIMEOUT-1: s_rvalid_o[owner]=1, s_err_o[owner]=1, rdata=0, timeout_o=1; go S_DRAIN.
//   - m_rvalid_i in the expiry cycle wins: normal response, no timeout.
//  S_DRAIN:
//   - No grants; m_req_o=0.
//   - m_rvalid_i is discarded (never forwarded); go S_IDLE.
//  Non-owner s_rvalid_o/s_err_o/s_rdata_o lanes are always 0.
//  Earliest back-to-back grant: the cycle after the response cycle.
//  A requester must hold req and fields stable until granted (Ibex rule); dropping req before gnt is legal.
//  Fairness: a requester continuously requesting is granted within NUM_REQ transactions.
//  wd_cnt width = $clog2(TIMEOUT+1) and saturates.
//  Reset mid-transaction returns to S_IDLE; the bridge's late rvalid is ignored there.
// TESTING
//  1. Req0 read 0x100, bridge gnt then rvalid rdata=0xDEADBEEF -> s_gnt_o=01, s_rvalid_o=01, s_rdata_o[0]=0xDEADBEEF, lane1=0.
//  2. Req0 and req1 held continuously from reset, 4 transactions -> grant order 0,1,0,1; rr_ptr wraps to 0.
//  3. Req1 write be=0x3, m_err_i=1 on response -> s_rvalid_o=10, s_err_o=10; next grant is >=1 cycle later.
//  4. TIMEOUT=8, bridge never responds -> s_rvalid_o[owner] and s_err_o pulse with timeout_o 7 cycles after the S_WAIT entry edge; late m_rvalid_i swallowed; next req granted after it.
//  5. TIMEOUT=8, m_rvalid_i exactly in the expiry cycle -> normal response, timeout_o=0, state S_IDLE.
//  6. Assert rst while in S_WAIT, then m_rvalid_i after release -> no s_rvalid_o; all outputs 0 during reset.

Source files
------------

// File: rtl/dev_port_arbiter.sv
// dev_port_arbiter
// Shares one Ibex-style device port between NUM_REQ requesters.
// Arbitration is round-robin, and at most one transaction is in flight at a time.
// The response is routed back to the requester that owns the transaction.
// A watchdog turns a lost response into an error response. The late reply is
// then absorbed in S_DRAIN so that it never reaches the next owner.
module dev_port_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      s_req_i,
    input  logic [NUM_REQ*32-1:0]   s_addr_i,
    input  logic [NUM_REQ-1:0]      s_we_i,
    input  logic [NUM_REQ*4-1:0]    s_be_i,
    input  logic [NUM_REQ*32-1:0]   s_wdata_i,
    output logic [NUM_REQ-1:0]      s_gnt_o,
    output logic [NUM_REQ-1:0]      s_rvalid_o,
    output logic [NUM_REQ-1:0]      s_err_o,
    output logic [NUM_REQ*32-1:0]   s_rdata_o,
    output logic                    m_req_o,
    output logic [31:0]             m_addr_o,
    output logic                    m_we_o,
    output logic [3:0]              m_be_o,
    output logic [31:0]             m_wdata_o,
    input  logic                    m_gnt_i,
    input  logic                    m_rvalid_i,
    input  logic                    m_err_i,
    input  logic [31:0]             m_rdata_i,
    output logic                    timeout_o
);

    localparam int IW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    // The watchdog counter needs at least one bit, even when the watchdog is disabled.
    localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WDW-1:0] WD_LAST = (TIMEOUT > 0) ? WDW'(TIMEOUT - 1) : '0;
    localparam logic [WDW-1:0] WD_MAX  = {WDW{1'b1}};
    localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_REQ - 1);
    localparam logic [IW:0]    NUM_W    = (IW + 1)'(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]     state_q, state_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IW-1:0]  owner_q, owner_d;
    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;

    // Per-requester request fields, unpacked from the flat buses.
    logic [31:0] req_addr  [NUM_REQ];
    logic        req_we    [NUM_REQ];
    logic [3:0]  req_be    [NUM_REQ];
    logic [31:0] req_wdata [NUM_REQ];

    logic [IW-1:0] win_idx;
    logic          win_found;
    logic [IW:0]   cand_sum;
    logic [IW-1:0] cand_idx;

    logic issue_req;
    logic grant_fire;
    logic resp_fire;
    logic to_fire;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_addr[gi]  = s_addr_i[32*gi +: 32];
            assign req_we[gi]    = s_we_i[gi];
            assign req_be[gi]    = s_be_i[4*gi +: 4];
            assign req_wdata[gi] = s_wdata_i[32*gi +: 32];
        end
    endgenerate

    // The round-robin search starts at rr_ptr. The first active request found is the winner.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand_sum = {1'b0, rr_ptr_q} + (IW + 1)'(i);
            if (cand_sum >= NUM_W) begin
                cand_sum = cand_sum - NUM_W;
            end
            cand_idx = cand_sum[IW-1:0];
            if (!win_found && s_req_i[cand_idx]) begin
                win_found = 1'b1;
                win_idx   = cand_idx;
            end
        end
    end

    // Outputs are gated by rst so that everything reads 0 while reset is asserted.
    assign issue_req  = !rst && (state_q == S_IDLE) && (|s_req_i);
    assign grant_fire = issue_req && m_gnt_i;
    assign resp_fire  = !rst && (state_q == S_WAIT) && m_rvalid_i;
    // A real response in the expiry cycle takes priority over the timeout.
    assign to_fire    = !rst && (TIMEOUT != 0) && (state_q == S_WAIT)
                        && !m_rvalid_i && (wd_cnt_q == WD_LAST);

    assign m_req_o   = issue_req;
    assign m_addr_o  = issue_req ? req_addr[win_idx]  : 32'd0;
    assign m_we_o    = issue_req ? req_we[win_idx]    : 1'b0;
    assign m_be_o    = issue_req ? req_be[win_idx]    : 4'd0;
    assign m_wdata_o = issue_req ? req_wdata[win_idx] : 32'd0;
    assign timeout_o = to_fire;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            logic is_win;
            logic is_owner;
            assign is_win   = (win_idx == IW'(gi));
            assign is_owner = (owner_q == IW'(gi));
            assign s_gnt_o[gi]           = grant_fire && is_win;
            assign s_rvalid_o[gi]        = is_owner && (resp_fire || to_fire);
            assign s_err_o[gi]           = is_owner && ((resp_fire && m_err_i) || to_fire);
            assign s_rdata_o[32*gi +: 32] = (is_owner && resp_fire) ? m_rdata_i : 32'd0;
        end
    endgenerate

    // Next-state logic: grant in IDLE, wait for the response or a timeout, then drain the late reply.
    always_comb begin
        state_d  = state_q;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        wd_cnt_d = wd_cnt_q;
        case (state_q)
            S_IDLE: begin
                if (grant_fire) begin
                    owner_d  = win_idx;
                    rr_ptr_d = (win_idx == LAST_IDX) ? '0 : win_idx + IW'(1);
                    wd_cnt_d = '0;
                    state_d  = S_WAIT;
                end
            end
            S_WAIT: begin
                if (m_rvalid_i) begin
                    state_d = S_IDLE;
                end else if (to_fire) begin
                    state_d = S_DRAIN;
                end else if (wd_cnt_q != WD_MAX) begin
                    wd_cnt_d = wd_cnt_q + WDW'(1);
                end
            end
            S_DRAIN: begin
                if (m_rvalid_i) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers. Reset returns to IDLE, so any reply still in flight is ignored there.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            wd_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            wd_cnt_q <= wd_cnt_d;
        end
    end

endmodule

// File: tb/tb_dev_port_arbiter.sv
// Testbench for dev_port_arbiter (NUM_REQ=2, TIMEOUT=8).
// A table of per-cycle vectors covers arbitration and response routing.
// Hand-written sequences cover the watchdog and reset corner cases.
module tb_dev_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  s_req_i;
    logic [63:0] s_addr_i;
    logic [1:0]  s_we_i;
    logic [7:0]  s_be_i;
    logic [63:0] s_wdata_i;
    logic [1:0]  s_gnt_o;
    logic [1:0]  s_rvalid_o;
    logic [1:0]  s_err_o;
    logic [63:0] s_rdata_o;
    logic        m_req_o;
    logic [31:0] m_addr_o;
    logic        m_we_o;
    logic [3:0]  m_be_o;
    logic [31:0] m_wdata_o;
    logic        m_gnt_i;
    logic        m_rvalid_i;
    logic        m_err_i;
    logic [31:0] m_rdata_i;
    logic        timeout_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    dev_port_arbiter #(.NUM_REQ(2), .TIMEOUT(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .s_req_i    (s_req_i),
        .s_addr_i   (s_addr_i),
        .s_we_i     (s_we_i),
        .s_be_i     (s_be_i),
        .s_wdata_i  (s_wdata_i),
        .s_gnt_o    (s_gnt_o),
        .s_rvalid_o (s_rvalid_o),
        .s_err_o    (s_err_o),
        .s_rdata_o  (s_rdata_o),
        .m_req_o    (m_req_o),
        .m_addr_o   (m_addr_o),
        .m_we_o     (m_we_o),
        .m_be_o     (m_be_o),
        .m_wdata_o  (m_wdata_o),
        .m_gnt_i    (m_gnt_i),
        .m_rvalid_i (m_rvalid_i),
        .m_err_i    (m_err_i),
        .m_rdata_i  (m_rdata_i),
        .timeout_o  (timeout_o)
    );

    typedef struct {
        string       nm;
        logic [1:0]  req;
        logic        gnt;
        logic        rv;
        logic        err;
        logic [31:0] rdata;
        logic [1:0]  e_gnt;
        logic        e_mreq;
        logic [1:0]  e_win;   // 0: no master fields, 1: requester 0, 2: requester 1
        logic [1:0]  e_rv;
        logic [1:0]  e_err;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input string nm, input logic [1:0] req, input logic gnt,
                                input logic rv, input logic err, input logic [31:0] rdata,
                                input logic [1:0] e_gnt, input logic e_mreq, input logic [1:0] e_win,
                                input logic [1:0] e_rv, input logic [1:0] e_err,
                                input logic [31:0] e_rd0, input logic [31:0] e_rd1);
        vec_t v;
        v.nm = nm; v.req = req; v.gnt = gnt; v.rv = rv; v.err = err; v.rdata = rdata;
        v.e_gnt = e_gnt; v.e_mreq = e_mreq; v.e_win = e_win; v.e_rv = e_rv;
        v.e_err = e_err; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic check_all(input string nm, input logic [1:0] e_gnt, input logic e_mreq,
                             input logic [1:0] e_win, input logic [1:0] e_rv, input logic [1:0] e_err,
                             input logic [31:0] e_rd0, input logic [31:0] e_rd1, input logic e_to);
        logic [31:0] ea, ew;
        logic        ewe;
        logic [3:0]  ebe;
        ea = 32'd0; ew = 32'd0; ewe = 1'b0; ebe = 4'd0;
        if (e_win == 2'd1) begin ea = 32'h100; ewe = 1'b0; ebe = 4'hF; ew = 32'h1111_1111; end
        if (e_win == 2'd2) begin ea = 32'h200; ewe = 1'b1; ebe = 4'h3; ew = 32'h2222_2222; end
        check({nm, ".gnt"},    {30'd0, s_gnt_o},    {30'd0, e_gnt});
        check({nm, ".mreq"},   {31'd0, m_req_o},    {31'd0, e_mreq});
        check({nm, ".maddr"},  m_addr_o,            ea);
        check({nm, ".mwe"},    {31'd0, m_we_o},     {31'd0, ewe});
        check({nm, ".mbe"},    {28'd0, m_be_o},     {28'd0, ebe});
        check({nm, ".mwdata"}, m_wdata_o,           ew);
        check({nm, ".rvalid"}, {30'd0, s_rvalid_o}, {30'd0, e_rv});
        check({nm, ".err"},    {30'd0, s_err_o},    {30'd0, e_err});
        check({nm, ".rdata0"}, s_rdata_o[31:0],     e_rd0);
        check({nm, ".rdata1"}, s_rdata_o[63:32],    e_rd1);
        check({nm, ".timeout"}, {31'd0, timeout_o}, {31'd0, e_to});
        $display("txn %-12s req=%b gnt=%b rvalid=%b err=%b to=%b", nm, s_req_i, s_gnt_o,
                 s_rvalid_o, s_err_o, timeout_o);
    endtask

    task automatic drive(input logic [1:0] req, input logic gnt, input logic rv,
                         input logic err, input logic [31:0] rdata);
        s_req_i    = req;
        m_gnt_i    = gnt;
        m_rvalid_i = rv;
        m_err_i    = err;
        m_rdata_i  = rdata;
    endtask

    // Drive just after the rising edge, then settle at the falling edge for sampling.
    task automatic step(input logic [1:0] req, input logic gnt, input logic rv,
                        input logic err, input logic [31:0] rdata);
        @(posedge clk);
        #1;
        drive(req, gnt, rv, err, rdata);
        @(negedge clk);
    endtask

    initial begin
        s_addr_i  = {32'h200, 32'h100};
        s_we_i    = 2'b10;
        s_be_i    = {4'h3, 4'hF};
        s_wdata_i = {32'h2222_2222, 32'h1111_1111};
        rst = 1'b1;
        drive(2'b11, 1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);

        // Round-robin between requests held from reset.
        vecs.push_back(mk("t2.stall", 2'b11, 0, 0, 0, 32'h0,  2'b00, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t2.g0",    2'b11, 1, 0, 0, 32'h0,  2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t2.r0",    2'b11, 0, 1, 0, 32'hA0, 2'b00, 0, 0, 2'b01, 2'b00, 32'hA0, 32'h0));
        vecs.push_back(mk("t2.g1",    2'b11, 1, 0, 0, 32'h0,  2'b10, 1, 2, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t2.r1",    2'b11, 0, 1, 0, 32'hA1, 2'b00, 0, 0, 2'b10, 2'b00, 32'h0, 32'hA1));
        vecs.push_back(mk("t2.g0b",   2'b11, 1, 0, 0, 32'h0,  2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t2.r0b",   2'b11, 0, 1, 0, 32'hA2, 2'b00, 0, 0, 2'b01, 2'b00, 32'hA2, 32'h0));
        vecs.push_back(mk("t2.g1b",   2'b11, 1, 0, 0, 32'h0,  2'b10, 1, 2, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t2.r1b",   2'b11, 0, 1, 0, 32'hA3, 2'b00, 0, 0, 2'b10, 2'b00, 32'h0, 32'hA3));
        vecs.push_back(mk("t2.wrap",  2'b11, 0, 0, 0, 32'h0,  2'b00, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0));
        // Single read from requester 0.
        vecs.push_back(mk("t1.gnt",   2'b01, 1, 0, 0, 32'h0,  2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t1.resp",  2'b00, 0, 1, 0, 32'hDEADBEEF, 2'b00, 0, 0, 2'b01, 2'b00, 32'hDEADBEEF, 32'h0));
        // Requester 1 write that gets an error response; no grant in the response cycle.
        vecs.push_back(mk("t3.gnt",   2'b10, 1, 0, 0, 32'h0,   2'b10, 1, 2, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t3.resp",  2'b10, 1, 1, 1, 32'h0BAD, 2'b00, 0, 0, 2'b10, 2'b10, 32'h0, 32'h0BAD));
        vecs.push_back(mk("t3.next",  2'b10, 1, 0, 0, 32'h0,   2'b10, 1, 2, 2'b00, 2'b00, 32'h0, 32'h0));
        vecs.push_back(mk("t3.resp2", 2'b00, 0, 1, 0, 32'h5,   2'b00, 0, 0, 2'b10, 2'b00, 32'h0, 32'h5));
        // A stray response while idle must be ignored.
        vecs.push_back(mk("stray",    2'b00, 0, 1, 1, 32'h77,  2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0));

        // All outputs stay 0 under reset, even while requests and bridge inputs are active.
        @(negedge clk);
        check_all("reset", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b00, 0, 0, 0, 32'h0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].req, vecs[i].gnt, vecs[i].rv, vecs[i].err, vecs[i].rdata);
            check_all(vecs[i].nm, vecs[i].e_gnt, vecs[i].e_mreq, vecs[i].e_win, vecs[i].e_rv,
                      vecs[i].e_err, vecs[i].e_rd0, vecs[i].e_rd1, 1'b0);
        end

        // Watchdog expiry 7 cycles after the S_WAIT entry edge, followed by a drained late reply.
        step(2'b01, 1, 0, 0, 32'h0);
        check_all("t4.gnt", 2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        for (int k = 0; k < 8; k++) begin
            step(2'b00, 0, 0, 0, 32'h0);
            if (k < 7) check_all("t4.wait", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
            else       check_all("t4.expire", 2'b00, 0, 0, 2'b01, 2'b01, 32'h0, 32'h0, 1);
        end
        step(2'b10, 1, 1, 0, 32'h77);
        check_all("t4.drain", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        step(2'b10, 1, 0, 0, 32'h0);
        check_all("t4.regrant", 2'b10, 1, 2, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        step(2'b00, 0, 1, 0, 32'h99);
        check_all("t4.resp", 2'b00, 0, 0, 2'b10, 2'b00, 32'h0, 32'h99, 0);

        // A response that arrives in the expiry cycle is delivered normally.
        step(2'b01, 1, 0, 0, 32'h0);
        check_all("t5.gnt", 2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        for (int k = 0; k < 7; k++) begin
            step(2'b00, 0, 0, 0, 32'h0);
            check_all("t5.wait", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        end
        step(2'b00, 0, 1, 0, 32'h55);
        check_all("t5.edge", 2'b00, 0, 0, 2'b01, 2'b00, 32'h55, 32'h0, 0);
        step(2'b01, 1, 0, 0, 32'h0);
        check_all("t5.idle", 2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        step(2'b00, 0, 1, 0, 32'h66);
        check_all("t5.resp", 2'b00, 0, 0, 2'b01, 2'b00, 32'h66, 32'h0, 0);

        // Reset asserted in S_WAIT: outputs go to 0, and the late reply after release is ignored.
        step(2'b01, 1, 0, 0, 32'h0);
        check_all("t6.gnt", 2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(2'b11, 1, 1, 1, 32'hCAFE);
        @(negedge clk);
        check_all("t6.in_rst", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(2'b00, 0, 1, 0, 32'h1234);
        @(negedge clk);
        check_all("t6.late", 2'b00, 0, 0, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        step(2'b11, 1, 0, 0, 32'h0);
        check_all("t6.rr_rst", 2'b01, 1, 1, 2'b00, 2'b00, 32'h0, 32'h0, 0);
        step(2'b00, 0, 1, 0, 32'h42);
        check_all("t6.resp", 2'b00, 0, 0, 2'b01, 2'b00, 32'h42, 32'h0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
